load_store_unit: RTL and testbench

//  Sequences CPU load/store requests into the byte-addressed data memory (registered read, 1-cycle write).

---
 rtl/load_store_unit.sv | 189 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store sequencer between execute stage and a byte-addressed data memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of splitting them into byte accesses.
//
//  state        | meaning
//  S_IDLE       | ready for a request, memory idle
//  S_ISSUE      | single aligned memory access
//  S_WAIT       | capture registered read data
//  S_SPLIT_ISSUE| byte access k of a misaligned request
//  S_SPLIT_WAIT | capture byte k of a misaligned load
//  S_RESP       | one-cycle response pulse
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_SPLIT_ISSUE, S_SPLIT_WAIT, S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] raw_q, raw_d;
  logic        error_q, error_d;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q;

  logic        accept;
  logic [2:0]  req_size;
  logic        funct3_bad, range_bad, misaligned;
  logic [1:0]  last_k;
  logic [31:0] ext_rdata;

  assign accept = req_valid && (state_q == S_IDLE);

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   req_size = 3'd1;
      2'b01:   req_size = 3'd2;
      default: req_size = 3'd4;
    endcase
  end

  assign funct3_bad = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                      (req_funct3 == 3'b111) || (req_write && req_funct3[2]);
  // 33-bit sum so addresses near 2^32 cannot wrap into range
  assign range_bad  = ({1'b0, req_addr} + {30'b0, req_size}) > 33'(MEM_BYTES);
  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign last_k     = funct3_q[1] ? 2'd3 : {1'b0, funct3_q[0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      k_q      <= 2'd0;
      raw_q    <= 32'd0;
      error_q  <= 1'b0;
      write_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      raw_q   <= raw_d;
      error_q <= error_d;
      if (accept) begin
        write_q  <= req_write;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    raw_d   = raw_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          k_d     = 2'd0;
          raw_d   = 32'd0;
          error_d = 1'b0;
          if (funct3_bad || range_bad) begin
            state_d = S_RESP;
            error_d = 1'b1;
          end else if (!misaligned) begin
            state_d = S_ISSUE;
          end else begin
`ifdef LSU_MISALIGN_TRAP_EN
            state_d = S_RESP;
            error_d = 1'b1;
`else
            state_d = S_SPLIT_ISSUE;
`endif
          end
        end
      end
      S_ISSUE: state_d = write_q ? S_RESP : S_WAIT;
      S_WAIT: begin
        raw_d   = mem_rdata;
        state_d = S_RESP;
      end
`ifndef LSU_MISALIGN_TRAP_EN
      S_SPLIT_ISSUE: begin
        if (!write_q)            state_d = S_SPLIT_WAIT;
        else if (k_q == last_k)  state_d = S_RESP;
        else                     k_d = k_q + 2'd1;
      end
      S_SPLIT_WAIT: begin
        raw_d[{k_q, 3'b000} +: 8] = mem_rdata[7:0];
        if (k_q == last_k) begin
          state_d = S_RESP;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = S_SPLIT_ISSUE;
        end
      end
`endif
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (funct3_q)
      3'b000:  ext_rdata = {{24{raw_q[7]}}, raw_q[7:0]};
      3'b001:  ext_rdata = {{16{raw_q[15]}}, raw_q[15:0]};
      3'b010:  ext_rdata = raw_q;
      3'b100:  ext_rdata = {24'd0, raw_q[7:0]};
      3'b101:  ext_rdata = {16'd0, raw_q[15:0]};
      default: ext_rdata = 32'd0;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_error = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_funct3 = 3'b000;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    case (state_q)
      S_ISSUE: begin
        mem_read   = !write_q;
        mem_write  = write_q;
        mem_funct3 = {1'b0, funct3_q[1:0]};
        mem_addr   = addr_q;
        mem_wdata  = write_q ? wdata_q : 32'd0;
      end
      S_SPLIT_ISSUE: begin
        mem_read  = !write_q;
        mem_write = write_q;
        mem_addr  = addr_q + {30'd0, k_q};
        mem_wdata = write_q ? {24'd0, wdata_q[{k_q, 3'b000} +: 8]} : 32'd0;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_error = error_q;
        resp_rdata = (write_q || error_q) ? 32'd0 : ext_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small byte-array memory model.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata;
  bit   [31:0] mem_rdata;

  always #5 clock = ~clock;

  load_store_unit dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // memory: registered read, 1-cycle write, unsigned B/H/W
  bit [7:0]  mem [1024];
  logic [9:0] ma;
  assign ma = mem_addr[9:0];

  always @(posedge clock) begin
    if (mem_write) begin
      case (mem_funct3)
        3'b000: mem[ma] <= mem_wdata[7:0];
        3'b001: begin mem[ma] <= mem_wdata[7:0]; mem[ma+10'd1] <= mem_wdata[15:8]; end
        3'b010: begin
          mem[ma]       <= mem_wdata[7:0];   mem[ma+10'd1] <= mem_wdata[15:8];
          mem[ma+10'd2] <= mem_wdata[23:16]; mem[ma+10'd3] <= mem_wdata[31:24];
        end
        default: ;
      endcase
    end
    if (mem_read) begin
      case (mem_funct3)
        3'b000:  mem_rdata <= {24'd0, mem[ma]};
        3'b001:  mem_rdata <= {16'd0, mem[ma+10'd1], mem[ma]};
        3'b010:  mem_rdata <= {mem[ma+10'd3], mem[ma+10'd2], mem[ma+10'd1], mem[ma]};
        default: mem_rdata <= 32'hBAD0BAD0;
      endcase
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] r_rdata, r_waddr, r_raddr;
  logic        r_err, r_ready;
  logic [2:0]  r_wf3, r_rf3;
  int          r_lat, r_nrd, r_nwr;

  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
    bit done;
    @(negedge clock);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clock);
    r_lat = 1; r_nrd = 0; r_nwr = 0; done = 1'b0;
    r_waddr = '1; r_raddr = '1; r_wf3 = '1; r_rf3 = '1; r_rdata = '1; r_err = 1'bx; r_ready = 1'bx;
    #1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clock);
      if (resp_valid) begin
        done = 1'b1; r_rdata = resp_rdata; r_err = resp_error; r_ready = req_ready;
      end else begin
        if (mem_read) begin
          if (r_nrd == 0) begin r_raddr = mem_addr; r_rf3 = mem_funct3; end
          r_nrd++;
        end
        if (mem_write) begin
          if (r_nwr == 0) begin r_waddr = mem_addr; r_wf3 = mem_funct3; end
          r_nwr++;
        end
        @(posedge clock);
        r_lat++;
      end
    end
    if (!done) check("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_err(input string tag);
    check({tag, "_err"}, {31'd0, r_err}, 32'd1);
    check({tag, "_rdata"}, r_rdata, 32'd0);
    check({tag, "_lat"}, r_lat, 32'd1);
    check({tag, "_access"}, r_nrd + r_nwr, 32'd0);
  endtask

  int bad;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp", {29'd0, resp_valid, resp_error, 1'b0}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_mem_ctl", {26'd0, mem_read, mem_write, 1'b0, mem_funct3}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    // aligned word store / load
    do_req(1'b1, 3'b010, 32'd8, 32'hDEADBEEF);
    check("sw8_lat", r_lat, 32'd2);
    check("sw8_nwr", r_nwr, 32'd1);
    check("sw8_addr", r_waddr, 32'd8);
    check("sw8_f3", {29'd0, r_wf3}, 32'd2);
    check("sw8_err", {31'd0, r_err}, 32'd0);
    check("sw8_rdata", r_rdata, 32'd0);
    check("sw8_ready_in_resp", {31'd0, r_ready}, 32'd0);
    do_req(1'b0, 3'b010, 32'd8, 32'd0);
    check("lw8_rdata", r_rdata, 32'hDEADBEEF);
    check("lw8_lat", r_lat, 32'd3);
    check("lw8_nrd", r_nrd, 32'd1);
    check("lw8_f3", {29'd0, r_rf3}, 32'd2);

    // byte store, signed/unsigned byte loads; upper wdata bytes must not matter
    do_req(1'b1, 3'b000, 32'd5, 32'hAAAAAA80);
    check("sb5_lat", r_lat, 32'd2);
    do_req(1'b0, 3'b000, 32'd5, 32'd0);
    check("lb5_rdata", r_rdata, 32'hFFFFFF80);
    check("lb5_f3", {29'd0, r_rf3}, 32'd0);
    do_req(1'b0, 3'b100, 32'd5, 32'd0);
    check("lbu5_rdata", r_rdata, 32'h00000080);
    check("lbu5_f3", {29'd0, r_rf3}, 32'd0);

    // halfword store, signed/unsigned halfword loads
    do_req(1'b1, 3'b001, 32'd2, 32'h55558001);
    check("sh2_f3", {29'd0, r_wf3}, 32'd1);
    do_req(1'b0, 3'b001, 32'd2, 32'd0);
    check("lh2_rdata", r_rdata, 32'hFFFF8001);
    do_req(1'b0, 3'b101, 32'd2, 32'd0);
    check("lhu2_rdata", r_rdata, 32'h00008001);

    // misaligned word store / load at 13
    do_req(1'b1, 3'b010, 32'd13, 32'h11223344);
`ifdef LSU_MISALIGN_TRAP_EN
    expect_err("sw13");
    do_req(1'b0, 3'b010, 32'd13, 32'd0);
    expect_err("lw13");
    do_req(1'b0, 3'b001, 32'd9, 32'd0);
    expect_err("lh9");
`else
    check("sw13_lat", r_lat, 32'd5);
    check("sw13_nwr", r_nwr, 32'd4);
    check("sw13_addr", r_waddr, 32'd13);
    check("sw13_f3", {29'd0, r_wf3}, 32'd0);
    check("sw13_err", {31'd0, r_err}, 32'd0);
    check("sw13_mem13", {24'd0, mem[13]}, 32'h44);
    check("sw13_mem16", {24'd0, mem[16]}, 32'h11);
    do_req(1'b0, 3'b010, 32'd13, 32'd0);
    check("lw13_rdata", r_rdata, 32'h11223344);
    check("lw13_lat", r_lat, 32'd9);
    check("lw13_nrd", r_nrd, 32'd4);
    check("lw13_f3", {29'd0, r_rf3}, 32'd0);
    // halfword at 9 spans bytes BE, AD of the earlier word store
    do_req(1'b0, 3'b001, 32'd9, 32'd0);
    check("lh9_rdata", r_rdata, 32'hFFFFADBE);
    check("lh9_lat", r_lat, 32'd5);
    check("lh9_nrd", r_nrd, 32'd2);
`endif

    // error cases and range boundaries
    do_req(1'b0, 3'b010, 32'd1022, 32'd0);
    expect_err("lw1022");
    do_req(1'b0, 3'b011, 32'd0, 32'd0);
    expect_err("f3_011");
    do_req(1'b1, 3'b100, 32'd0, 32'h12345678);
    expect_err("sbu");
    do_req(1'b0, 3'b001, 32'hFFFFFFFE, 32'd0);
    expect_err("lh_wrap");
    do_req(1'b0, 3'b010, 32'd1020, 32'd0);
    check("lw1020_err", {31'd0, r_err}, 32'd0);
    check("lw1020_lat", r_lat, 32'd3);
    do_req(1'b0, 3'b100, 32'd1023, 32'd0);
    check("lbu1023_err", {31'd0, r_err}, 32'd0);
    check("lbu1023_nrd", r_nrd, 32'd1);

    // reset during WAIT aborts the load
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'd8;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    check("abort_issue_read", {31'd0, mem_read}, 32'd1);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    check("abort_mem_ctl", {26'd0, mem_read, mem_write, 1'b0, mem_funct3}, 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid || mem_read || mem_write) bad++;
      @(negedge clock);
    end
    check("abort_quiet", bad, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
